hazard_unit: RTL

- Pipeline hazard responder for the 5-stage RV32I core.
- Consumes the pipelined control outputs (RegWriteM, RegWriteW, ResultSrcE, PCSrcE) and decode-stage register addresses.
- Produces forwarding selects, stall and flush controls. Its FlushE output drives the control unit's E-stage register clear.
- Keeps its own shadow pipeline of Rs1/Rs2/Rd addresses (E, M, W), aligned with the control pipeline registers.

---
 rtl/hazard_unit_if.sv | 36 +++
 rtl/hazard_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: decode addresses and pipelined control in, forwarding/stall/flush controls
// and performance counters out. The master side is the pipeline; the slave side is hazard_unit.
interface hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic [1:0]        ResultSrcE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              PCSrcE;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [CNT_W-1:0]  StallCnt;
    logic [CNT_W-1:0]  FlushCnt;
    logic [CNT_W-1:0]  FwdCnt;

    modport master (
        output Rs1D, Rs2D, RdD, ResultSrcE, RegWriteM, RegWriteW, PCSrcE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  StallCnt, FlushCnt, FwdCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, ResultSrcE, RegWriteM, RegWriteW, PCSrcE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output StallCnt, FlushCnt, FwdCnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch flush control for the 5-stage RV32I pipeline.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_unit_if.slave bus
);
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]        fwd_a, fwd_b;
    logic              lw_stall;
    logic              stall, flush_d, flush_e;

    // x0 is hard-wired zero, so it never takes a forwarded value.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic [REG_AW-1:0] rdw,
        input logic              wem,
        input logic              wew
    );
        if (rs != '0 && rs == rdm && wem)      return 2'b10;
        else if (rs != '0 && rs == rdw && wew) return 2'b01;
        else                                   return 2'b00;
    endfunction

    // NOTE: every output of a combinational block gets a value before any branch, so no latch is inferred.
    always_comb begin
        lw_stall = (bus.ResultSrcE == 2'b01) && (rd_e != '0) &&
                   ((bus.Rs1D == rd_e) || (bus.Rs2D == rd_e));
        fwd_a    = fwd_sel(rs1_e, rd_m, rd_w, bus.RegWriteM, bus.RegWriteW);
        fwd_b    = fwd_sel(rs2_e, rd_m, rd_w, bus.RegWriteM, bus.RegWriteW);
        stall    = lw_stall & ~bus.PCSrcE;
        flush_d  = bus.PCSrcE;
        flush_e  = lw_stall | bus.PCSrcE;
        if (reset) begin
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
            stall   = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign bus.ForwardAE = fwd_a;
    assign bus.ForwardBE = fwd_b;
    assign bus.StallF    = stall;
    assign bus.StallD    = stall;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
        end else begin
            rs1_e <= bus.Rs1D;
            rs2_e <= bus.Rs2D;
            rd_e  <= bus.RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_m <= '0;
            rd_w <= '0;
        end else begin
            rd_m <= rd_e;
            rd_w <= rd_m;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, fwd_cnt;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.PCSrcE && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if ((fwd_a != 2'b00 || fwd_b != 2'b00) && fwd_cnt != '1)
                fwd_cnt <= fwd_cnt + CNT_W'(1);
        end
    end

    assign bus.StallCnt = stall_cnt;
    assign bus.FlushCnt = flush_cnt;
    assign bus.FwdCnt   = fwd_cnt;
`else
    assign bus.StallCnt = {CNT_W{1'b0}};
    assign bus.FlushCnt = {CNT_W{1'b0}};
    assign bus.FwdCnt   = {CNT_W{1'b0}};
`endif
endmodule
